// File: rtl/sys_ctrl_frame.sv
// Command-frame controller: decodes UART RX frames, drives RF/ALU, returns bytes to TX.
// Build option ERR_RESP_EN: reply 0xEE to an unknown command byte instead of ignoring it.
module sys_ctrl_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_DATA_VLD,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  input  logic                    TX_BUSY,
  output logic [ADDR_WIDTH-1:0]   RF_ADDR,
  output logic                    RF_WR_EN,
  output logic                    RF_RD_EN,
  output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_AL = DATA_WIDTH'(8'hDD);
`ifdef ERR_RESP_EN
  localparam logic [DATA_WIDTH-1:0] ERR_BYTE = DATA_WIDTH'(8'hEE);
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_ALU_FUN,
    S_ALU_WAIT,
    S_TX_SEND,
    S_TX_WAIT
  } state_t;

  state_t                  state;
  // Pending TX bytes, low byte sent first; shifted down per send.
  logic [2*DATA_WIDTH-1:0] tx_buf;
  logic [1:0]              tx_left;
  // Set once TX_BUSY is seen high after a strobe, so one strobe
  // can never be mistaken for a finished transmission.
  logic                    busy_seen;

  // Frame FSM with all outputs registered; strobes default low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      tx_buf      <= '0;
      tx_left     <= '0;
      busy_seen   <= 1'b0;
      RF_ADDR     <= '0;
      RF_WR_EN    <= 1'b0;
      RF_RD_EN    <= 1'b0;
      RF_WR_DATA  <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
    end else begin
      RF_WR_EN <= 1'b0;
      RF_RD_EN <= 1'b0;
      TX_D_VLD <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_DATA == CMD_WR) begin
              state <= S_WR_ADDR;
            end else if (RX_P_DATA == CMD_RD) begin
              state <= S_RD_ADDR;
            end else if (RX_P_DATA == CMD_AL) begin
              state <= S_ALU_FUN;
            end else begin
`ifdef ERR_RESP_EN
              tx_buf  <= {{DATA_WIDTH{1'b0}}, ERR_BYTE};
              tx_left <= 2'd1;
              state   <= S_TX_SEND;
`else
              state   <= S_IDLE;
`endif
            end
          end
        end
        S_WR_ADDR: begin
          if (RX_D_VLD) begin
            RF_ADDR <= RX_P_DATA[ADDR_WIDTH-1:0];
            state   <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (RX_D_VLD) begin
            RF_WR_DATA <= RX_P_DATA;
            RF_WR_EN   <= 1'b1;
            state      <= S_IDLE;
          end
        end
        S_RD_ADDR: begin
          if (RX_D_VLD) begin
            RF_ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
            RF_RD_EN <= 1'b1;
            state    <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (RF_RD_DATA_VLD) begin
            tx_buf  <= {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
            tx_left <= 2'd1;
            state   <= S_TX_SEND;
          end
        end
        S_ALU_FUN: begin
          if (RX_D_VLD) begin
            ALU_FUN     <= RX_P_DATA[FUN_WIDTH-1:0];
            ALU_EN      <= 1'b1;
            CLK_GATE_EN <= 1'b1;
            state       <= S_ALU_WAIT;
          end
        end
        S_ALU_WAIT: begin
          if (ALU_OUT_VLD) begin
            ALU_EN      <= 1'b0;
            CLK_GATE_EN <= 1'b0;
            tx_buf      <= ALU_OUT;
            tx_left     <= 2'd2;
            state       <= S_TX_SEND;
          end
        end
        S_TX_SEND: begin
          if (!TX_BUSY) begin
            TX_P_DATA <= tx_buf[DATA_WIDTH-1:0];
            TX_D_VLD  <= 1'b1;
            tx_buf    <= tx_buf >> DATA_WIDTH;
            tx_left   <= tx_left - 2'd1;
            busy_seen <= 1'b0;
            state     <= S_TX_WAIT;
          end
        end
        S_TX_WAIT: begin
          if (!busy_seen) begin
            if (TX_BUSY) begin
              busy_seen <= 1'b1;
            end
          end else if (!TX_BUSY) begin
            if (tx_left != 2'd0) begin
              state <= S_TX_SEND;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_ctrl_frame.sv
// Randomized bench for sys_ctrl_frame with RF/ALU/TX responders.
// Expected traffic is derived from frame contents and a shadow register file.
module tb_sys_ctrl_frame;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic [7:0]  RF_RD_DATA = '0;
  logic        RF_RD_DATA_VLD = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VLD = 1'b0;
  logic        TX_BUSY;
  logic        tx_busy_r = 1'b0;
  logic        hold_busy = 1'b0;
  logic [3:0]  RF_ADDR;
  logic        RF_WR_EN;
  logic        RF_RD_EN;
  logic [7:0]  RF_WR_DATA;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic        CLK_GATE_EN;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;

  assign TX_BUSY = tx_busy_r | hold_busy;

  sys_ctrl_frame dut (
    .CLK           (CLK),
    .RST           (RST),
    .RX_P_DATA     (RX_P_DATA),
    .RX_D_VLD      (RX_D_VLD),
    .RF_RD_DATA    (RF_RD_DATA),
    .RF_RD_DATA_VLD(RF_RD_DATA_VLD),
    .ALU_OUT       (ALU_OUT),
    .ALU_OUT_VLD   (ALU_OUT_VLD),
    .TX_BUSY       (TX_BUSY),
    .RF_ADDR       (RF_ADDR),
    .RF_WR_EN      (RF_WR_EN),
    .RF_RD_EN      (RF_RD_EN),
    .RF_WR_DATA    (RF_WR_DATA),
    .ALU_EN        (ALU_EN),
    .ALU_FUN       (ALU_FUN),
    .CLK_GATE_EN   (CLK_GATE_EN),
    .TX_P_DATA     (TX_P_DATA),
    .TX_D_VLD      (TX_D_VLD)
  );

  always #5 CLK = ~CLK;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [11:0] wr_q[$];
  logic [11:0] exp_wr[$];
  logic [3:0]  rd_q[$];
  logic [3:0]  exp_rd[$];
  logic [3:0]  alu_q[$];
  logic [3:0]  exp_alu[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  rf_mem[16];
  logic [7:0]  ref_mem[16];
  int          gate_err = 0;
  int          bsy_err = 0;
  logic        alu_en_q = 1'b0;
  logic [15:0] alu_val = '0;
  logic [3:0]  last_addr = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, ALU_EN,
                ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD});
  endfunction

  // Observe strobes and record traffic.
  always @(negedge CLK) begin
    if (!RST) begin
      if (RF_WR_EN) begin
        wr_q.push_back({RF_ADDR, RF_WR_DATA});
        rf_mem[RF_ADDR] = RF_WR_DATA;
      end
      if (RF_RD_EN) rd_q.push_back(RF_ADDR);
      if (TX_D_VLD) begin
        tx_q.push_back(TX_P_DATA);
        if (TX_BUSY) bsy_err++;
      end
      if (ALU_EN && !alu_en_q) alu_q.push_back(ALU_FUN);
      if (CLK_GATE_EN !== ALU_EN) gate_err++;
    end
    alu_en_q = ALU_EN;
  end

  // Register file read responder.
  initial begin
    logic [3:0] a;
    forever begin
      @(negedge CLK);
      if (RF_RD_EN && !RST) begin
        a = RF_ADDR;
        repeat ($urandom_range(1, 4)) @(posedge CLK);
        #1 RF_RD_DATA = rf_mem[a];
        RF_RD_DATA_VLD = 1'b1;
        @(posedge CLK);
        #1 RF_RD_DATA_VLD = 1'b0;
      end
    end
  end

  // ALU responder.
  initial begin
    forever begin
      @(negedge CLK);
      if (ALU_EN && !RST) begin
        repeat ($urandom_range(1, 4)) @(posedge CLK);
        #1 ALU_OUT = alu_val;
        ALU_OUT_VLD = 1'b1;
        @(posedge CLK);
        #1 ALU_OUT_VLD = 1'b0;
      end
    end
  end

  // UART transmitter model: busy for a few cycles after each strobe.
  initial begin
    forever begin
      @(negedge CLK);
      if (TX_D_VLD && !RST) begin
        @(posedge CLK);
        #1 tx_busy_r = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge CLK);
        #1 tx_busy_r = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK);
    #1 RX_P_DATA = b;
    RX_D_VLD = 1'b1;
    @(posedge CLK);
    #1 RX_D_VLD = 1'b0;
  endtask

  task automatic finish_frame(input string nm);
    int n;
    n = 0;
    while (n < 400 && tx_q.size() < exp_tx.size()) begin
      @(negedge CLK);
      n++;
    end
    chk({nm, "_tmo"}, 32'(n >= 400), 0);
    repeat (8) @(negedge CLK);
    chk({nm, "_wr_n"}, 32'(wr_q.size()), 32'(exp_wr.size()));
    foreach (exp_wr[i])
      if (i < wr_q.size()) chk({nm, "_wr"}, 32'(wr_q[i]), 32'(exp_wr[i]));
    chk({nm, "_rd_n"}, 32'(rd_q.size()), 32'(exp_rd.size()));
    foreach (exp_rd[i])
      if (i < rd_q.size()) chk({nm, "_rd"}, 32'(rd_q[i]), 32'(exp_rd[i]));
    chk({nm, "_alu_n"}, 32'(alu_q.size()), 32'(exp_alu.size()));
    foreach (exp_alu[i])
      if (i < alu_q.size()) chk({nm, "_fun"}, 32'(alu_q[i]), 32'(exp_alu[i]));
    chk({nm, "_tx_n"}, 32'(tx_q.size()), 32'(exp_tx.size()));
    foreach (exp_tx[i])
      if (i < tx_q.size()) chk({nm, "_tx"}, 32'(tx_q[i]), 32'(exp_tx[i]));
    chk({nm, "_gate"}, 32'(gate_err), 0);
    chk({nm, "_tx_in_busy"}, 32'(bsy_err), 0);
    chk({nm, "_alu_en_off"}, 32'(ALU_EN), 0);
    chk({nm, "_rf_addr"}, 32'(RF_ADDR), 32'(last_addr));
    wr_q.delete(); exp_wr.delete();
    rd_q.delete(); exp_rd.delete();
    alu_q.delete(); exp_alu.delete();
    tx_q.delete(); exp_tx.delete();
    gate_err = 0;
    bsy_err = 0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    send_byte(8'hAA);
    send_byte(a);
    send_byte(d);
    exp_wr.push_back({a[3:0], d});
    ref_mem[a[3:0]] = d;
    last_addr = a[3:0];
    finish_frame("wr");
  endtask

  task automatic do_read(input logic [7:0] a, input bit junk);
    send_byte(8'hBB);
    send_byte(a);
    if (junk) send_byte(8'hAA);
    exp_rd.push_back(a[3:0]);
    exp_tx.push_back(ref_mem[a[3:0]]);
    last_addr = a[3:0];
    finish_frame("rd");
  endtask

  task automatic do_alu(input logic [7:0] f, input logic [15:0] v,
                        input bit junk);
    alu_val = v;
    send_byte(8'hDD);
    send_byte(f);
    if (junk) send_byte(8'hBB);
    exp_alu.push_back(f[3:0]);
    exp_tx.push_back(v[7:0]);
    exp_tx.push_back(v[15:8]);
    finish_frame("alu");
  endtask

  task automatic do_unk(input logic [7:0] c);
    send_byte(c);
`ifdef ERR_RESP_EN
    exp_tx.push_back(8'hEE);
`endif
    finish_frame("unk");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;
    for (int i = 0; i < 16; i++) begin
      rf_mem[i]  = 8'(i * 29 + 7);
      ref_mem[i] = 8'(i * 29 + 7);
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_outs", outs(), 0);
    @(posedge CLK);
    #1 RST = 1'b0;

    do_write(8'h05, 8'h3C);
    do_read(8'h05, 1'b0);
    do_alu(8'h02, 16'h1234, 1'b0);

    hold_busy = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h05);
    exp_rd.push_back(4'h5);
    exp_tx.push_back(ref_mem[5]);
    last_addr = 4'h5;
    repeat (4) @(posedge CLK);
    send_byte(8'hAA);
    send_byte(8'h03);
    send_byte(8'h99);
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    chk("hold_no_tx", 32'(tx_q.size()), 0);
    @(posedge CLK);
    #1 hold_busy = 1'b0;
    finish_frame("hold");

    send_byte(8'hAA);
    send_byte(8'h05);
    @(posedge CLK);
    #1 RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_mid_outs", outs(), 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    last_addr = '0;
    do_write(8'h01, 8'h77);

    do_unk(8'h55);
    do_read(8'hF1, 1'b1);

    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      case ($urandom_range(0, 3))
        0: do_write(8'($urandom), 8'($urandom));
        1: do_read(8'($urandom), 1'($urandom));
        2: do_alu(8'($urandom), 16'($urandom), 1'($urandom));
        default: begin
          c = 8'($urandom);
          while (c == 8'hAA || c == 8'hBB || c == 8'hDD) c = 8'($urandom);
          do_unk(c);
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
